// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: opcodes, FSM states, accumulator source select codes.
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_JMP  = 5'b01010;

    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

endpackage

// File: rtl/bip_program_counter.sv
// Program counter register: load-zero wins over everything; when enabled, a target load wins
// over increment; increment wraps modulo 2^AW.
module bip_program_counter #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          load_zero,
    input  logic          load_target,
    input  logic          incr,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (load_zero) begin
            pc <= '0;
        end else if (en) begin
            if (load_target) begin
                pc <= target;
            end else if (incr) begin
                pc <= pc + AW'(1);
            end
        end
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP sequencer: run/halt FSM, PC, decoder and sticky illegal-opcode flag; one instruction per unstalled RUN cycle.
// Define BIP_BRANCH_EN to decode BEQ/BNE/JMP; otherwise those opcodes are illegal NOPs.
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int AW = 11,
    parameter int OW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic [4:0]    OpCode,
    input  logic [OW-1:0] Operand,
    input  logic          AccZero,
    output logic [AW-1:0] Addr,
    output logic [1:0]    SelA,
    output logic          SelB,
    output logic          WrAcc,
    output logic          Op,
    output logic          WrRam,
    output logic          RdRam,
    output logic          Halted,
    output logic          Illegal
);

    state_t state, state_nxt;
    logic   retire;
    logic   pc_load_zero, pc_load_target, pc_incr;
    logic   illegal_set, illegal_clr;

`ifndef BIP_BRANCH_EN
    logic unused_inputs;
    assign unused_inputs = ^{AccZero, Operand};
`endif

    assign retire = (state == ST_RUN) && !Stall;

    always_comb begin
        state_nxt      = state;
        pc_load_zero   = 1'b0;
        pc_load_target = 1'b0;
        pc_incr        = 1'b0;
        illegal_set    = 1'b0;
        illegal_clr    = 1'b0;
        SelA           = SELA_RAM;
        SelB           = 1'b0;
        WrAcc          = 1'b0;
        Op             = 1'b0;
        WrRam          = 1'b0;
        RdRam          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_nxt    = ST_RUN;
                    pc_load_zero = 1'b1;
                end
            end
            ST_HALT: begin
                if (Start) begin
                    state_nxt    = ST_RUN;
                    pc_load_zero = 1'b1;
                    illegal_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                if (retire) begin
                    pc_incr = 1'b1;
                    case (OpCode)
                        OP_HLT: begin
                            pc_incr   = 1'b0;
                            state_nxt = ST_HALT;
                        end
                        OP_STO:  WrRam = 1'b1;
                        OP_LD: begin
                            RdRam = 1'b1;
                            SelA  = SELA_RAM;
                            WrAcc = 1'b1;
                        end
                        OP_LDI: begin
                            SelA  = SELA_IMM;
                            WrAcc = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            RdRam = 1'b1;
                            SelB  = 1'b1;
                            SelA  = SELA_ALU;
                            WrAcc = 1'b1;
                            Op    = (OpCode == OP_SUB);
                        end
                        OP_ADDI, OP_SUBI: begin
                            SelA  = SELA_ALU;
                            WrAcc = 1'b1;
                            Op    = (OpCode == OP_SUBI);
                        end
`ifdef BIP_BRANCH_EN
                        OP_BEQ:  pc_load_target = AccZero;
                        OP_BNE:  pc_load_target = !AccZero;
                        OP_JMP:  pc_load_target = 1'b1;
`endif
                        default: illegal_set = 1'b1;
                    endcase
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Illegal <= 1'b0;
        end else if (illegal_clr) begin
            Illegal <= 1'b0;
        end else if (illegal_set) begin
            Illegal <= 1'b1;
        end
    end

    assign Halted = (state == ST_HALT);

    bip_program_counter #(.AW(AW)) u_pc (
        .clk         (clk),
        .reset       (reset),
        .en          (retire),
        .load_zero   (pc_load_zero),
        .load_target (pc_load_target),
        .incr        (pc_incr),
        .target      (Operand[AW-1:0]),
        .pc          (Addr)
    );

endmodule

// File: tb/tb_bip_control_unit.sv
// Randomised and directed bench for bip_control_unit against a behavioural instruction-level model.
module tb_bip_control_unit;

    localparam int AW = 4;
    localparam int OW = 8;
    localparam int PC_MOD = 1 << AW;
`ifdef BIP_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          Start, Stall, AccZero;
    logic [4:0]    OpCode;
    logic [OW-1:0] Operand;
    logic [AW-1:0] Addr;
    logic [1:0]    SelA;
    logic          SelB, WrAcc, Op, WrRam, RdRam, Halted, Illegal;

    int checks = 0;
    int failures = 0;

    int m_pc;
    bit m_run, m_halt, m_ill;

    bip_control_unit #(.AW(AW), .OW(OW)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Stall(Stall),
        .OpCode(OpCode), .Operand(Operand), .AccZero(AccZero),
        .Addr(Addr), .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc), .Op(Op),
        .WrRam(WrRam), .RdRam(RdRam), .Halted(Halted), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {SelA, SelB, WrAcc, Op, WrRam, RdRam} for a retiring instruction.
    function automatic logic [6:0] exp_dec(input logic [4:0] opc, input bit ret);
        if (!ret) return 7'b0;
        case (opc)
            5'd1:    return 7'b00_0_0_0_1_0;
            5'd2:    return 7'b00_0_1_0_0_1;
            5'd3:    return 7'b01_0_1_0_0_0;
            5'd4:    return 7'b10_1_1_0_0_1;
            5'd5:    return 7'b10_0_1_0_0_0;
            5'd6:    return 7'b10_1_1_1_0_1;
            5'd7:    return 7'b10_0_1_1_0_0;
            default: return 7'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0; m_run = 0; m_halt = 0; m_ill = 0;
    endtask

    task automatic cycle(input bit st, input bit stl, input logic [4:0] opc,
                         input logic [OW-1:0] opnd, input bit az);
        bit ret;
        int tgt;
        @(negedge clk);
        Start = st; Stall = stl; OpCode = opc; Operand = opnd; AccZero = az;
        #1;
        ret = m_run && !stl;
        chk("addr", 32'(Addr), 32'(m_pc));
        chk("halted", 32'(Halted), 32'(m_halt));
        chk("illegal", 32'(Illegal), 32'(m_ill));
        chk("decode", 32'({SelA, SelB, WrAcc, Op, WrRam, RdRam}), 32'(exp_dec(opc, ret)));
        tgt = int'(opnd) % PC_MOD;
        if (!m_run) begin
            if (st) begin
                if (m_halt) m_ill = 0;
                m_run = 1; m_halt = 0; m_pc = 0;
            end
        end else if (ret) begin
            if (opc == 5'd0) begin
                m_run = 0; m_halt = 1;
            end else if (BR && opc == 5'd10) begin
                m_pc = tgt;
            end else if (BR && opc == 5'd8) begin
                m_pc = az ? tgt : (m_pc + 1) % PC_MOD;
            end else if (BR && opc == 5'd9) begin
                m_pc = !az ? tgt : (m_pc + 1) % PC_MOD;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
                if (opc > 5'd10 || (!BR && opc >= 5'd8)) m_ill = 1;
            end
        end
    endtask

    initial begin
        logic [4:0] ropc;
        int r;
        Start = 0; Stall = 0; OpCode = 5'd3; Operand = '0; AccZero = 0;
        reset = 1;
        model_reset();
        #12;
        reset = 0;

        // Idle: Start not yet given, nothing retires
        cycle(0, 0, 5'd3, 8'd0, 0);
        cycle(1, 0, 5'd3, 8'd0, 0);
        // LDI, ADDI, STO, HLT then hold
        cycle(0, 0, 5'd3, 8'd7, 0);
        cycle(0, 0, 5'd5, 8'd1, 0);
        cycle(0, 0, 5'd1, 8'd4, 0);
        cycle(0, 0, 5'd0, 8'd0, 0);
        cycle(0, 0, 5'd3, 8'd0, 0);
        cycle(0, 0, 5'd3, 8'd0, 0);
        // Restart, reach address 5, stalled ADD, then wrap through 15
        cycle(1, 0, 5'd3, 8'd0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 5'd3, 8'(i), 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 5'd4, 8'd2, 0);
        cycle(0, 0, 5'd4, 8'd2, 0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 5'd3, 8'd0, 0);
        // Branch / illegal behaviour (expectations depend on build)
        cycle(0, 0, 5'd10, 8'd2, 0);
        cycle(0, 0, 5'd8, 8'd9, 1);
        cycle(0, 0, 5'd9, 8'd9, 1);
        cycle(0, 0, 5'd9, 8'd12, 0);
        cycle(0, 0, 5'd31, 8'd0, 0);
        cycle(0, 1, 5'd0, 8'd0, 0);
        cycle(0, 0, 5'd3, 8'd0, 0);
        cycle(0, 0, 5'd0, 8'd0, 0);
        cycle(1, 0, 5'd3, 8'd0, 0);
        cycle(0, 0, 5'd3, 8'd0, 0);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 15);
            if (r < 12)       ropc = 5'($urandom_range(1, 10));
            else if (r == 12) ropc = 5'd0;
            else              ropc = 5'($urandom_range(0, 31));
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, ropc,
                  8'($urandom), $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset mid-run
        cycle(1, 0, 5'd3, 8'd0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 5'd3, 8'd0, 0);
        @(negedge clk);
        #2;
        reset = 1;
        #1;
        chk("rst_addr", 32'(Addr), 32'd0);
        chk("rst_halted", 32'(Halted), 32'd0);
        chk("rst_wracc", 32'(WrAcc), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        reset = 0;
        for (int i = 0; i < 4; i++) cycle(0, 0, 5'd4, 8'd0, 0);
        cycle(1, 0, 5'd4, 8'd0, 0);
        cycle(0, 0, 5'd4, 8'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
